// File: rtl/motion_pkg.sv
// motion_pkg: shared zone state and mode encodings for the motion lighting controller.
package motion_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ON     = 2'b01,
        WARN   = 2'b10,
        FORCED = 2'b11
    } zone_state_t;

    // Mode encoding 2'b11 has no member and behaves as AUTO.
    typedef enum logic [1:0] {
        AUTO      = 2'b00,
        FORCE_ON  = 2'b01,
        FORCE_OFF = 2'b10
    } zone_mode_t;

endpackage

// File: rtl/motion_zone_fsm.sv
// motion_zone_fsm: one lighting zone (synchroniser, debounce, inactivity timer, FSM).
// Ports: clk_i, rst_n_i (async active-low), motion_i (raw sensor), mode_i (zone_mode_t),
//        light_o / warn_o (registered outputs), light_d_o (next value of light_o).
// Optional MOTION_PREWARN_EN adds the WARN state and the warn_o output.
module motion_zone_fsm
    import motion_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 1000000,
    parameter int unsigned TIMER_W         = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 4
`ifdef MOTION_PREWARN_EN
    ,
    parameter int unsigned WARN_CYCLES     = 1000
`endif
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       motion_i,
    input  logic [1:0] mode_i,
    output logic       light_o,
    output logic       warn_o,
    output logic       light_d_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic               sync1_q, sync2_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    zone_state_t        state_q, state_d;
    logic               force_on_q, force_on_d;
    logic               light_q, light_d;
    logic               force_on, force_off, forced, motion_ok, timeout;

    assign force_on  = mode_i == FORCE_ON;
    assign force_off = mode_i == FORCE_OFF;
    assign forced    = force_on | force_off;
    assign motion_ok = cnt_q == CNT_W'(DEBOUNCE_CYCLES);
    assign timeout   = timer_q == TIMER_W'(TIMEOUT_CYCLES - 1);

    always_comb begin
        // Held at zero during FORCE_OFF so motion present on return must re-qualify.
        cnt_d      = (force_off || !sync2_q) ? '0 : motion_ok ? cnt_q : cnt_q + 1'b1;
        state_d    = state_q;
        timer_d    = timer_q + 1'b1;
        force_on_d = force_on_q;
        if (forced) begin
            state_d    = FORCED;
            timer_d    = '0;
            force_on_d = force_on;
        end else begin
            case (state_q)
                IDLE: begin
                    timer_d = '0;
                    if (motion_ok) state_d = ON;
                end
                ON: begin
                    if (motion_ok) timer_d = '0;
                    else if (timeout) state_d = IDLE;
`ifdef MOTION_PREWARN_EN
                    else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - WARN_CYCLES - 1)) state_d = WARN;
`endif
                end
`ifdef MOTION_PREWARN_EN
                WARN: begin
                    if (motion_ok) begin
                        state_d = ON;
                        timer_d = '0;
                    end else if (timeout) state_d = IDLE;
                end
`endif
                FORCED: begin
                    timer_d = '0;
                    if (force_on_q) state_d = ON;
                    else state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        light_d = state_d == ON || state_d == WARN || (state_d == FORCED && force_on_d);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            cnt_q      <= '0;
            timer_q    <= '0;
            state_q    <= IDLE;
            force_on_q <= 1'b0;
            light_q    <= 1'b0;
        end else begin
            sync1_q    <= motion_i;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            state_q    <= state_d;
            force_on_q <= force_on_d;
            light_q    <= light_d;
        end
    end

    assign light_o   = light_q;
    assign light_d_o = light_d;

`ifdef MOTION_PREWARN_EN
    logic warn_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) warn_q <= 1'b0;
        else warn_q <= state_d == WARN;
    end

    assign warn_o = warn_q;
`else
    assign warn_o = 1'b0;
`endif

endmodule

// File: rtl/motion_zone_ctrl.sv
// motion_zone_ctrl: N_ZONES independent motion-activated lighting zones.
// Ports: clk, reset (async active-low), motion[N_ZONES] (raw PIR), mode[2*N_ZONES]
//        (per-zone zone_mode_t), lights_on / warn (registered per zone), any_on (registered OR).
// Optional MOTION_PREWARN_EN enables the pre-off warn outputs.
module motion_zone_ctrl
    import motion_pkg::*;
#(
    parameter int unsigned N_ZONES         = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000,
    parameter int unsigned TIMER_W         = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned WARN_CYCLES     = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_ZONES-1:0]   motion,
    input  logic [2*N_ZONES-1:0] mode,
    output logic [N_ZONES-1:0]   lights_on,
    output logic [N_ZONES-1:0]   warn,
    output logic                 any_on
);

    logic [N_ZONES-1:0] light_d;
    logic               any_on_q;

    for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
        motion_zone_fsm #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .TIMER_W        (TIMER_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef MOTION_PREWARN_EN
            ,
            .WARN_CYCLES    (WARN_CYCLES)
`endif
        ) u_zone (
            .clk_i    (clk),
            .rst_n_i  (reset),
            .motion_i (motion[i]),
            .mode_i   (mode[2*i +: 2]),
            .light_o  (lights_on[i]),
            .warn_o   (warn[i]),
            .light_d_o(light_d[i])
        );
    end

    // Registered from next-state lights so any_on changes on the same edge as lights_on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) any_on_q <= 1'b0;
        else any_on_q <= |light_d;
    end

    assign any_on = any_on_q;

endmodule

// File: tb/tb_motion_zone_ctrl.sv
// tb_motion_zone_ctrl: directed self-checking bench for motion_zone_ctrl.
module tb_motion_zone_ctrl;

`ifdef MOTION_PREWARN_EN
    localparam bit PW = 1'b1;
`else
    localparam bit PW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] motion = '0;
    logic [7:0] mode = '0;
    logic [3:0] lights_on, warn;
    logic       any_on;
    int         n_checks = 0;
    int         n_fail = 0;

    motion_zone_ctrl #(
        .N_ZONES(4), .TIMEOUT_CYCLES(20), .TIMER_W(8), .DEBOUNCE_CYCLES(3), .WARN_CYCLES(5)
    ) dut (
        .clk(clk), .reset(reset), .motion(motion), .mode(mode),
        .lights_on(lights_on), .warn(warn), .any_on(any_on)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({lights_on, warn, any_on} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got lights=%b warn=%b any=%b expected all 0", lights_on, warn, any_on);
        end
        tick();
        tick();
        reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_checks++;
            if ({lights_on, warn, any_on} !== 9'b0) begin
                n_fail++;
                $display("FAIL reset_release[%0d]: got lights=%b warn=%b any=%b expected all 0", j, lights_on, warn, any_on);
            end
        end
    endtask

    task automatic test_motion_on_off;
        logic [3:0] el, ew;
        motion[0] = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            tick();
            el = (e == 5) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (lights_on !== el || any_on !== (e == 5)) begin
                n_fail++;
                $display("FAIL z0_rise[%0d]: got lights=%b any=%b expected lights=%b", e, lights_on, any_on, el);
            end
        end
        motion[0] = 1'b0;
        for (int j = 0; j <= 22; j++) begin
            tick();
            el = (j < 22) ? 4'b0001 : 4'b0000;
            ew = (PW && j >= 17 && j < 22) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (lights_on !== el || warn !== ew || any_on !== (j < 22)) begin
                n_fail++;
                $display("FAIL z0_off[%0d]: got lights=%b warn=%b any=%b expected lights=%b warn=%b", j, lights_on, warn, any_on, el, ew);
            end
        end
    endtask

    task automatic test_debounce_reject;
        motion[1] = 1'b1;
        tick();
        tick();
        motion[1] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            n_checks++;
            if (lights_on !== 4'b0000 || any_on !== 1'b0) begin
                n_fail++;
                $display("FAIL z1_reject[%0d]: got lights=%b any=%b expected lights=0000", j, lights_on, any_on);
            end
        end
    endtask

    task automatic test_warn_retrigger;
        logic [3:0] el, ew;
        motion[2] = 1'b1;
        for (int e = 0; e <= 5; e++) tick();
        n_checks++;
        if (lights_on !== 4'b0100) begin
            n_fail++;
            $display("FAIL z2_on: got lights=%b expected 0100", lights_on);
        end
        // Last motion_ok of the first burst is at edge 2; the 3-edge pulse at 15..17 qualifies at edge 20.
        for (int j = 0; j <= 40; j++) begin
            motion[2] = (j >= 15 && j <= 17);
            tick();
            el = (j < 40) ? 4'b0100 : 4'b0000;
            ew = (PW && ((j >= 17 && j < 20) || (j >= 35 && j < 40))) ? 4'b0100 : 4'b0000;
            n_checks++;
            if (lights_on !== el || warn !== ew) begin
                n_fail++;
                $display("FAIL z2_retrig[%0d]: got lights=%b warn=%b expected lights=%b warn=%b", j, lights_on, warn, el, ew);
            end
        end
        motion[2] = 1'b0;
    endtask

    task automatic test_force_on;
        logic [3:0] el, ew;
        mode[7:6] = 2'b01;
        tick();
        n_checks++;
        if (lights_on !== 4'b1000 || any_on !== 1'b1) begin
            n_fail++;
            $display("FAIL z3_force_on: got lights=%b any=%b expected lights=1000 any=1", lights_on, any_on);
        end
        for (int j = 0; j < 100; j++) begin
            tick();
            if (j % 25 == 24) begin
                n_checks++;
                if (lights_on !== 4'b1000 || warn !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL z3_force_hold[%0d]: got lights=%b warn=%b expected lights=1000 warn=0000", j, lights_on, warn);
                end
            end
        end
        mode[7:6] = 2'b00;
        for (int j = 0; j <= 20; j++) begin
            tick();
            el = (j < 20) ? 4'b1000 : 4'b0000;
            ew = (PW && j >= 15 && j < 20) ? 4'b1000 : 4'b0000;
            n_checks++;
            if (lights_on !== el || warn !== ew) begin
                n_fail++;
                $display("FAIL z3_auto_off[%0d]: got lights=%b warn=%b expected lights=%b warn=%b", j, lights_on, warn, el, ew);
            end
        end
    endtask

    task automatic test_force_off;
        logic [3:0] el;
        motion[0] = 1'b1;
        for (int e = 0; e <= 5; e++) tick();
        n_checks++;
        if (lights_on !== 4'b0001) begin
            n_fail++;
            $display("FAIL z0_pre_force: got lights=%b expected 0001", lights_on);
        end
        mode[1:0] = 2'b10;
        for (int j = 0; j < 5; j++) begin
            tick();
            n_checks++;
            if (lights_on !== 4'b0000 || any_on !== 1'b0) begin
                n_fail++;
                $display("FAIL z0_force_off[%0d]: got lights=%b any=%b expected lights=0000 any=0", j, lights_on, any_on);
            end
        end
        mode[1:0] = 2'b00;
        for (int j = 0; j <= 3; j++) begin
            tick();
            el = (j >= 3) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (lights_on !== el) begin
                n_fail++;
                $display("FAIL z0_requalify[%0d]: got lights=%b expected %b", j, lights_on, el);
            end
        end
    endtask

    task automatic test_reset_mid;
        motion = 4'hF;
        for (int e = 0; e <= 5; e++) tick();
        n_checks++;
        if (lights_on !== 4'hF || any_on !== 1'b1) begin
            n_fail++;
            $display("FAIL all_on: got lights=%b any=%b expected lights=1111 any=1", lights_on, any_on);
        end
        motion = 4'h0;
        for (int j = 0; j <= 17; j++) tick();
        n_checks++;
        if (lights_on !== 4'hF || warn !== (PW ? 4'hF : 4'h0)) begin
            n_fail++;
            $display("FAIL all_warn: got lights=%b warn=%b expected lights=1111 warn=%b", lights_on, warn, PW ? 4'hF : 4'h0);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({lights_on, warn, any_on} !== 9'b0) begin
            n_fail++;
            $display("FAIL async_reset: got lights=%b warn=%b any=%b expected all 0", lights_on, warn, any_on);
        end
        tick();
        reset = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            n_checks++;
            if ({lights_on, warn, any_on} !== 9'b0) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got lights=%b warn=%b any=%b expected all 0", j, lights_on, warn, any_on);
            end
        end
    endtask

    initial begin
        test_reset();
        test_motion_on_off();
        test_debounce_reject();
        test_warn_retrigger();
        test_force_on();
        test_force_off();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/motion_zone_ctrl.md
# motion_zone_ctrl

Multi-zone, parametrised motion-activated lighting controller. Each of N_ZONES zones independently synchronises and debounces its motion input, turns its light on, and holds it for a programmable inactivity timeout, with per-zone manual mode (auto / force-on / force-off). It sits between the raw PIR sensor inputs and the lighting driver outputs of the home-automation core.

## Interface
- N_ZONES, 4, number of independent zones (1..16)
- TIMEOUT_CYCLES, 1000000, inactivity cycles before light-off (≥ 2)
- TIMER_W, 32, timer width; must satisfy 2^TIMER_W > TIMEOUT_CYCLES
- DEBOUNCE_CYCLES, 4, consecutive synced-high samples needed to accept motion (≥ 1)
- WARN_CYCLES, 1000, length of pre-off warning window (< TIMEOUT_CYCLES; used only with MOTION_PREWARN_EN)

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-low; the polarity and synchronicity are fixed
- motion  in  N_ZONES  raw asynchronous sensor inputs, bit i = zone i
- mode  in  2*N_ZONES  per-zone mode, bits [2i+1:2i]: 00 AUTO, 01 FORCE_ON, 10 FORCE_OFF, 11 treated as AUTO
- lights_on  out  N_ZONES  registered light enable per zone
- warn  out  N_ZONES  registered pre-off warning per zone (constant 0 without MOTION_PREWARN_EN)
- any_on  out  1  registered OR of lights_on

## Operation
- Per-zone 2-FF synchroniser on motion[i] -> m_sync.
- Debounce counter: increments while m_sync=1, clears to 0 on m_sync=0. The event motion_ok is asserted when the counter reaches DEBOUNCE_CYCLES; the counter saturates there.
- Per-zone FSM states: IDLE, ON, WARN, FORCED.
  - IDLE: lights_on=0. On motion_ok -> ON, timer cleared.
  - ON: lights_on=1. Timer increments each cycle and clears on any cycle with motion_ok. When timer = TIMEOUT_CYCLES-1 and motion_ok=0 -> IDLE. With MOTION_PREWARN_EN, when timer = TIMEOUT_CYCLES-WARN_CYCLES-1 and motion_ok=0 -> WARN.
  - WARN: lights_on=1, warn=1, timer keeps counting. On motion_ok -> ON, timer cleared. When timer = TIMEOUT_CYCLES-1 -> IDLE.
  - FORCED: entered from any state whenever mode ≠ AUTO. Under FORCE_ON, lights_on=1. Under FORCE_OFF, lights_on=0. In both cases warn=0 and the timer is held at 0. Returning to AUTO from FORCE_ON -> ON, with the timer starting fresh. Returning to AUTO from FORCE_OFF -> IDLE, with the debounce counter cleared so that stale motion must re-qualify.
- Mode takes priority over motion on the same cycle.
- Zones are fully independent; simultaneous events in different zones never interact.
- The timer never wraps because the transition out of ON/WARN occurs before overflow.

## Timing
- Reset (asynchronous assert, synchronous release): all states IDLE; lights_on=0, warn=0, any_on=0; synchronisers, debounce counters and timers at 0.
- Motion latency: with motion[i] held high from before edge 0, lights_on[i] rises after edge 2+DEBOUNCE_CYCLES.
- Off latency: lights_on falls exactly TIMEOUT_CYCLES edges after the last edge on which motion_ok was 1.
- Warn latency: warn rises TIMEOUT_CYCLES-WARN_CYCLES edges after the last motion_ok and falls together with lights_on.
- Mode change: lights_on/warn reflect the new mode one edge after mode is sampled.
- any_on lags lights_on by 0 cycles; it is derived from next-state values and registered in the same edge.
- Reset asserted mid-timeout: outputs clear immediately, asynchronously.

## Configuration
- MOTION_PREWARN_EN defined: the WARN state, the warn outputs and the WARN_CYCLES comparison are compiled in.
- MOTION_PREWARN_EN undefined: WARN is unreachable and removed, warn is tied to 0, and ON goes directly to IDLE at timeout. All other timing is identical.

## Structure
- Shared package motion_pkg: zone_state_t enum (IDLE, ON, WARN, FORCED) and zone_mode_t enum (AUTO, FORCE_ON, FORCE_OFF) with their 2-bit encodings.
- Sub-module motion_zone_fsm: one zone, containing the synchroniser, debounce, timer and FSM, instantiated N_ZONES times by a generate loop. The top level only slices mode and computes any_on.

## Test plan
Configuration for all tests: N_ZONES=4, DEBOUNCE_CYCLES=3, TIMEOUT_CYCLES=20, WARN_CYCLES=5, MOTION_PREWARN_EN defined unless stated.
- Motion on zone 0 held high from edge 0 -> lights_on=4'b0001 after edge 5. Drop motion -> lights_on returns to 0 exactly 20 edges after the last motion_ok; warn[0] high for the final 5 of those.
- Motion pulse of 2 cycles on zone 1 -> lights_on[1] never rises (debounce reject).
- Zone 2 in WARN, then a 3-cycle-qualified motion -> warn[2]=0, state ON, and the full 20-cycle timeout restarts.
- mode zone 3 = FORCE_ON with no motion -> lights_on[3]=1 after one edge, held for 100 cycles. Switch to AUTO -> light off 20 edges later.
- FORCE_OFF asserted on zone 0 while motion is held high -> lights_on[0]=0. Switch to AUTO with motion still high -> light on 3 edges later, after re-debounce.
- Reset pulsed low mid-timeout with all zones on -> all outputs 0 immediately. Rebuild without MOTION_PREWARN_EN -> warn stays 4'b0000 and off timing is unchanged.
